des_perm_pipe: RTL and testbench
================================

Name: des_perm_pipe

Overview:
- Parametrised, pipelined DES bit-permutation unit.
- Applies either the Initial Permutation (IP) or its inverse (IP^-1 / final permutation) to a 64-bit block.
- Optional left/right half swap before permuting; valid/ready handshake on both sides; tag sideband.
- Sits at the entry (IP) and exit (IP^-1) of the round datapath, so one instance can serve both ends of a time-multiplexed DES core.

Parameters:
- PIPE_STAGES, 2, number of register stages from input acceptance to output; legal values 1..4.
- TAG_W, 4, width of the opaque tag carried alongside each block; legal values 1..16.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  unit can accept the input this cycle.
- in_mode  in  1  0 = IP, 1 = IP^-1.
- in_swap  in  1  1 = form the word as {in_right,in_left}; 0 = {in_left,in_right}.
- in_left  in  32  upper half, or L16 in IP^-1 use.
- in_right  in  32  lower half, or R16.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  64  permuted block.
- out_tag  out  TAG_W  tag of the block on out_data.
- busy  out  1  any pipeline stage holds valid data.
- done_cnt  out  CNT_W  count of output transfers, wraps modulo 2^CNT_W.

Behaviour:
- Bit numbering follows the DES standard: bit 1 is the MSB (out_data[63]) and bit 64 is the LSB. Output bit n takes the value of word bit T[n].
- IP table T, n = 1..64: 58 50 42 34 26 18 10 2, 60 52 44 36 28 20 12 4, 62 54 46 38 30 22 14 6, 64 56 48 40 32 24 16 8, 57 49 41 33 25 17 9 1, 59 51 43 35 27 19 11 3, 61 53 45 37 29 21 13 5, 63 55 47 39 31 23 15 7.
- IP^-1 table T: 40 8 48 16 56 24 64 32, 39 7 47 15 55 23 63 31, 38 6 46 14 54 22 62 30, 37 5 45 13 53 21 61 29, 36 4 44 12 52 20 60 28, 35 3 43 11 51 19 59 27, 34 2 42 10 50 18 58 26, 33 1 41 9 49 17 57 25.
- The swap and the permutation are combinational in front of stage 1. Stages 2..PIPE_STAGES only register data.
- Each stage holds valid, data[63:0] and tag.
- Stage k loads when it is empty or when stage k+1 loads in the same cycle. The last stage loads when it is empty or out_ready=1.
- Input transfer occurs on in_valid && in_ready. in_ready = stage-1 load condition. in_ready must not depend combinationally on in_valid.
- Output transfer occurs on out_valid && out_ready. out_valid, out_data and out_tag are driven by the last stage.
- Latency is PIPE_STAGES cycles when no stall occurs. Throughput is 1 block/cycle with out_ready held high.
- Stall: with out_ready=0, the pipe fills to PIPE_STAGES entries and then in_ready=0. out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Releasing out_ready lets every stage advance in the same cycle. No bubble is inserted and no block is dropped or duplicated.
- Simultaneous input and output transfer on a full pipe is legal and keeps occupancy unchanged.
- in_mode and in_swap are sampled per block at input transfer. Mixed modes back-to-back are allowed.
- busy = OR of all stage valids.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset is synchronous; when rst=1 at a rising edge, on the following cycle:
  - all stage valids = 0, all data and tags = 0;
  - out_valid = 0, out_data = 0, out_tag = 0;
  - busy = 0, done_cnt = 0;
  - in_ready = 1.
- Reset mid-operation discards in-flight blocks. Reset has priority over any transfer in the same cycle.
- When out_valid=0, no handshake on the output side has any effect.

Test Plan:
- IP, PIPE_STAGES=2: in_mode=0, in_swap=0, left=0x01234567, right=0x89ABCDEF, tag=3 -> 2 cycles later out_data=0xCC00CCFFF0AAF0AA, out_tag=3, done_cnt=1 after the transfer.
- IP^-1 with swap: in_mode=1, in_swap=1, left=0x43423234, right=0x0A4CD995 -> out_data=0x85E813540F0AB405.
- Round trip: feed 1000 random blocks through IP, then feed each result back through IP^-1 (swap=0) -> the original block is recovered every time; tags are preserved in order.
- Backpressure: out_ready=0 while streaming -> exactly PIPE_STAGES blocks accepted, then in_ready=0. Raise out_ready for 1 cycle -> one output and one input transfer. Full sequence ordered, no loss or duplication; out_data stable during stall.
- Random in_valid/out_ready at 50% for 5000 cycles, for PIPE_STAGES = 1, 2, 4 -> scoreboard matches; done_cnt equals the output transfer count mod 2^CNT_W. With CNT_W=4, done_cnt wraps 15 -> 0.
- Assert rst for 1 cycle with the pipe full and out_ready=0 -> next cycle out_valid=0, busy=0, done_cnt=0, in_ready=1; the first block after reset emerges with correct data after PIPE_STAGES cycles.

Source files
------------

// File: rtl/des_perm_pipe.sv
// DES IP / IP^-1 bit-permutation unit with optional half swap.
// Ports: in_* valid/ready input side, out_* result side, busy, done_cnt.
module des_perm_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_swap,
  input  logic [31:0]      in_left,
  input  logic [31:0]      in_right,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int S = PIPE_STAGES;

  // Source bit (1 = MSB) for each output bit n = 1..64.
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9,  49, 17, 57, 25
  };

  function automatic logic [63:0] permute(
    input logic [63:0] w,
    input logic        inv
  );
    logic [63:0] p;
    logic [5:0]  src;
    logic [5:0]  dst;
    p = '0;
    for (int n = 0; n < 64; n++) begin
      src = inv ? 6'(64 - FP_T[n]) : 6'(64 - IP_T[n]);
      dst = 6'(63 - n);
      p[dst] = w[src];
    end
    return p;
  endfunction

  logic [S-1:0]     v;
  logic [63:0]      d [S];
  logic [TAG_W-1:0] t [S];
  logic [S-1:0]     ld;
  logic [63:0]      word;
  logic [63:0]      perm;
  logic [CNT_W-1:0] cnt;

  assign word = in_swap ? {in_right, in_left}
                        : {in_left, in_right};
  assign perm = permute(word, in_mode);

  // Stage k can load iff some stage at or after k is empty,
  // or the consumer takes the last stage this cycle.
  always_comb begin
    logic hole;
    ld   = '0;
    hole = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      hole  = hole | ~v[k];
      ld[k] = hole;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      cnt <= '0;
      for (int k = 0; k < S; k++) begin
        d[k] <= '0;
        t[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        d[0] <= perm;
        t[0] <= in_tag;
      end
      for (int k = 1; k < S; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
          t[k] <= t[k-1];
        end
      end
      if (v[S-1] && out_ready)
        cnt <= cnt + 1'b1;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[S-1];
  assign out_data  = d[S-1];
  assign out_tag   = t[S-1];
  assign busy      = |v;
  assign done_cnt  = cnt;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed and randomised bench for des_perm_pipe.
// Scenario tasks compare outputs against constants and a table-free model.
module tb_des_perm_pipe;

  localparam int PS = 2;
  localparam int TW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic          in_swap;
  logic [31:0]   in_left;
  logic [31:0]   in_right;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          busy;
  logic [CW-1:0] done_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  logic [63:0]   exp_d [$];
  logic [TW-1:0] exp_t [$];

  des_perm_pipe #(
    .PIPE_STAGES(PS),
    .TAG_W(TW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_swap(in_swap),
    .in_left(in_left),
    .in_right(in_right),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .busy(busy),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Reference count of output transfers.
  always @(posedge clk) begin
    if (rst) n_out <= 0;
    else if (out_valid && out_ready) n_out <= n_out + 1;
  end

  // Closed-form IP / IP^-1 (row/column formulas, bit 1 = MSB).
  function automatic logic [63:0] model(
    input logic [63:0] w,
    input logic        inv
  );
    logic [63:0] p;
    int n, s;
    p = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        n = 8 * r + c + 1;
        if (!inv)
          s = (r < 4) ? 58 + 2 * r - 8 * c
                      : 57 + 2 * (r - 4) - 8 * c;
        else
          s = ((c % 2) == 0) ? 40 - r + 8 * (c / 2)
                             : 8 - r + 8 * (c / 2);
        p[64 - n] = w[64 - s];
      end
    return p;
  endfunction

  task automatic drive(
    input logic          v,
    input logic          m,
    input logic          s,
    input logic [31:0]   l,
    input logic [31:0]   r,
    input logic [TW-1:0] tg,
    input logic          ordy
  );
    @(negedge clk);
    in_valid  = v;
    in_mode   = m;
    in_swap   = s;
    in_left   = l;
    in_right  = r;
    in_tag    = tg;
    out_ready = ordy;
    #1;
  endtask

  task automatic push_in();
    logic [63:0] w;
    w = in_swap ? {in_right, in_left} : {in_left, in_right};
    exp_d.push_back(model(w, in_mode));
    exp_t.push_back(in_tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_d.delete();
    exp_t.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    end
    if (done_cnt !== '0) begin
      n_bad++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt);
    end
    if (out_data !== 64'h0) begin
      n_bad++; $display("FAIL rst_out_data got=%h exp=0", out_data);
    end
    if (out_tag !== '0) begin
      n_bad++; $display("FAIL rst_out_tag got=%h exp=0", out_tag);
    end
  endtask

  task automatic test_ip_vector();
    logic [CW-1:0] c0;
    c0 = CW'(n_out);
    drive(1, 0, 0, 32'h01234567, 32'h89ABCDEF, 4'd3, 1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ip_accept got=%b exp=1", in_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ip_early got=%b exp=0", out_valid);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 3;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL ip_latency got=%b exp=1", out_valid);
    end
    if (out_data !== 64'hCC00CCFFF0AAF0AA) begin
      n_bad++;
      $display("FAIL ip_data got=%h exp=CC00CCFFF0AAF0AA", out_data);
    end
    if (out_tag !== 4'd3) begin
      n_bad++; $display("FAIL ip_tag got=%h exp=3", out_tag);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (done_cnt !== CW'(c0 + 1'b1)) begin
      n_bad++;
      $display("FAIL ip_done_cnt got=%0d exp=%0d", done_cnt, c0 + 1'b1);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL ip_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_ipinv_swap();
    drive(1, 1, 1, 32'h43423234, 32'h0A4CD995, 4'hA, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 3;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL inv_valid got=%b exp=1", out_valid);
    end
    if (out_data !== 64'h85E813540F0AB405) begin
      n_bad++;
      $display("FAIL inv_data got=%h exp=85E813540F0AB405", out_data);
    end
    if (out_tag !== 4'hA) begin
      n_bad++; $display("FAIL inv_tag got=%h exp=a", out_tag);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_round_trip();
    localparam int N = 1000;
    logic [63:0]   src [$];
    logic [TW-1:0] stg [$];
    logic [63:0]   mid [$];
    logic [TW-1:0] mtg [$];
    logic [63:0]   w;
    int i, j, cyc;
    for (int k = 0; k < N; k++) begin
      src.push_back({$urandom, $urandom});
      stg.push_back(TW'($urandom));
    end
    for (int pass = 0; pass < 2; pass++) begin
      i = 0; j = 0; cyc = 0;
      while (j < N && cyc < 4 * N) begin
        w = (pass == 0) ? src[i < N ? i : 0] : mid[i < N ? i : 0];
        drive(i < N, pass[0], 0, w[63:32], w[31:0],
              (pass == 0) ? stg[i < N ? i : 0] : mtg[i < N ? i : 0], 1);
        if (in_valid && in_ready) i++;
        if (out_valid && out_ready) begin
          n_cmp += 2;
          if (pass == 0) begin
            if (out_data !== model(src[j], 1'b0)) begin
              n_bad++;
              $display("FAIL rt_ip_data[%0d] got=%h exp=%h",
                       j, out_data, model(src[j], 1'b0));
            end
            mid.push_back(out_data);
            mtg.push_back(out_tag);
          end else if (out_data !== src[j]) begin
            n_bad++;
            $display("FAIL rt_recover[%0d] got=%h exp=%h",
                     j, out_data, src[j]);
          end
          if (out_tag !== stg[j]) begin
            n_bad++;
            $display("FAIL rt_tag[%0d] got=%h exp=%h", j, out_tag, stg[j]);
          end
          j++;
        end
        cyc++;
      end
      n_cmp++;
      if (j != N) begin
        n_bad++;
        $display("FAIL rt_timeout pass=%0d got=%0d exp=%0d", pass, j, N);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    int acc;
    logic [63:0]   hold_d;
    logic [TW-1:0] hold_t;
    acc = 0;
    hold_d = '0;
    hold_t = '0;
    for (int k = 0; k < 6; k++) begin
      drive(1, k[0], k[1], 32'h1000 + k, 32'hF0F0_0000 + k, TW'(k), 0);
      if (in_valid && in_ready) begin
        acc++;
        push_in();
      end
      if (k == 2) begin
        hold_d = out_data;
        hold_t = out_tag;
      end
    end
    n_cmp += 4;
    if (acc != PS) begin
      n_bad++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, PS);
    end
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
    end
    if (out_data !== hold_d || out_tag !== hold_t) begin
      n_bad++;
      $display("FAIL bp_stable got=%h/%h exp=%h/%h",
               out_data, out_tag, hold_d, hold_t);
    end
    if (out_data !== exp_d[0]) begin
      n_bad++; $display("FAIL bp_head got=%h exp=%h", out_data, exp_d[0]);
    end
    drive(1, 1, 0, 32'hDEADBEEF, 32'h0BADF00D, 4'h9, 1);
    n_cmp += 2;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_full_in got=%b exp=1", in_ready);
    end
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_full_out got=%b exp=1", out_valid);
    end
    if (in_valid && in_ready) push_in();
    if (out_valid && out_ready) begin
      void'(exp_d.pop_front());
      void'(exp_t.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_occupancy got=%b exp=0", in_ready);
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_bad++; $display("FAIL bp_extra got=%h exp=none", out_data);
        end else if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
          n_bad++;
          $display("FAIL bp_order got=%h/%h exp=%h/%h",
                   out_data, out_tag, exp_d[0], exp_t[0]);
        end
        if (exp_d.size() != 0) begin
          void'(exp_d.pop_front());
          void'(exp_t.pop_front());
        end
      end
    end
    n_cmp++;
    if (exp_d.size() != 0) begin
      n_bad++; $display("FAIL bp_lost got=%0d exp=0", exp_d.size());
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 5040; k++) begin
      drive((k < 5000) ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom), 1'($urandom), $urandom, $urandom,
            TW'($urandom),
            (k < 5000) ? 1'($urandom_range(0, 1)) : 1'b1);
      if (in_valid && in_ready) push_in();
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra got=%h exp=none", out_data);
        end else begin
          if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
            n_bad++;
            if (bad < 5)
              $display("FAIL rnd_data got=%h/%h exp=%h/%h",
                       out_data, out_tag, exp_d[0], exp_t[0]);
            bad++;
          end
          void'(exp_d.pop_front());
          void'(exp_t.pop_front());
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (exp_d.size() != 0) begin
      n_bad++; $display("FAIL rnd_lost got=%0d exp=0", exp_d.size());
    end
    if (done_cnt !== CW'(n_out)) begin
      n_bad++;
      $display("FAIL rnd_done_cnt got=%0d exp=%0d", done_cnt, CW'(n_out));
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int k = 0; k < 15; k++)
      drive(1, 0, 0, k, k, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (done_cnt !== 4'd15) begin
      n_bad++; $display("FAIL wrap_15 got=%0d exp=15", done_cnt);
    end
    drive(1, 0, 0, 1, 2, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (done_cnt !== 4'd0) begin
      n_bad++; $display("FAIL wrap_0 got=%0d exp=0", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 32'h11111111, 32'h22222222, 4'h1, 0);
    drive(1, 0, 0, 32'h33333333, 32'h44444444, 4'h2, 0);
    drive(1, 0, 0, 32'h55555555, 32'h66666666, 4'h3, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_busy got=%b exp=0", busy);
    end
    if (done_cnt !== '0) begin
      n_bad++; $display("FAIL mid_done_cnt got=%0d exp=0", done_cnt);
    end
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready);
    end
    if (out_data !== 64'h0) begin
      n_bad++; $display("FAIL mid_out_data got=%h exp=0", out_data);
    end
    drive(1, 0, 0, 32'h01234567, 32'h89ABCDEF, 4'h7, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (out_valid !== 1'b1 || out_data !== 64'hCC00CCFFF0AAF0AA) begin
      n_bad++;
      $display("FAIL mid_first got=%b/%h exp=1/CC00CCFFF0AAF0AA",
               out_valid, out_data);
    end
    if (out_tag !== 4'h7) begin
      n_bad++; $display("FAIL mid_tag got=%h exp=7", out_tag);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_swap = 1'b0;
    in_left = '0;
    in_right = '0;
    in_tag = '0;
    out_ready = 1'b0;
    test_reset();
    test_ip_vector();
    test_ipinv_swap();
    test_round_trip();
    test_backpressure();
    test_random();
    test_cnt_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
